// File: rtl/updown_button_ctrl.sv
// Two-button front end for a 2-bit up/down saturating counter: sync, debounce,
// arbitration and single-cycle enable pulses with a direction bit.
//
// Ports:
//   clk       posedge clock
//   rst       synchronous active-high reset
//   btn_up    raw up button (async)
//   btn_down  raw down button (async)
//   enable    one-cycle command pulse to the counter
//   up_down   direction of the last pulse (1=up, 0=down)
//   held      high in HELD_UP, HELD_DOWN or WAIT_REL
//
// Optional feature macro: AUTO_REPEAT_EN (auto-repeat while a single button
// is held). Without it, exactly one pulse is issued per press.
module updown_button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_PERIOD   = 10000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
    output logic enable,
    output logic up_down,
    output logic held
);

    localparam int MAXV =
        (DEBOUNCE_CYCLES > REPEAT_DELAY)
            ? ((DEBOUNCE_CYCLES > REPEAT_PERIOD) ? DEBOUNCE_CYCLES : REPEAT_PERIOD)
            : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam int CW = $clog2(MAXV) + 1;

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD_UP,
        HELD_DOWN,
        WAIT_REL
    } state_t;

    // Bit 0 = up button, bit 1 = down button.
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    db;
    logic [1:0]    db_q;
    logic [CW-1:0] cnt [2];

    logic rise_up;
    logic rise_dn;
    logic db_up;
    logic db_dn;

    state_t state;
    state_t state_n;
    logic   start_pulse;
    logic   rep_fire;
    logic   enable_n;
    logic   up_down_n;

    // Synchroniser and per-button debounce counter. The counter only runs
    // while the synced level disagrees with the debounced one, so any
    // disagreement shorter than DEBOUNCE_CYCLES is forgotten.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            db     <= '0;
            db_q   <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            s1   <= {btn_down, btn_up};
            s2   <= s1;
            db_q <= db;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign db_up   = db[0];
    assign db_dn   = db[1];
    assign rise_up = db[0] & ~db_q[0];
    assign rise_dn = db[1] & ~db_q[1];

    always_comb begin
        state_n     = state;
        start_pulse = 1'b0;
        up_down_n   = up_down;
        unique case (state)
            IDLE: begin
                if (rise_up && rise_dn) begin
                    state_n = WAIT_REL;
                end else if (rise_up && !db_dn) begin
                    state_n     = HELD_UP;
                    start_pulse = 1'b1;
                    up_down_n   = 1'b1;
                end else if (rise_dn && !db_up) begin
                    state_n     = HELD_DOWN;
                    start_pulse = 1'b1;
                    up_down_n   = 1'b0;
                end
            end
            HELD_UP: begin
                if (db_dn) begin
                    state_n = WAIT_REL;
                end else if (!db_up) begin
                    state_n = IDLE;
                end
            end
            HELD_DOWN: begin
                if (db_up) begin
                    state_n = WAIT_REL;
                end else if (!db_dn) begin
                    state_n = IDLE;
                end
            end
            WAIT_REL: begin
                if (!db_up && !db_dn) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

    // rep_phase=0: waiting out the initial delay; 1: periodic repeats.
    // The counter restarts at each pulse so it never needs to wrap.
    logic [CW-1:0] rep_cnt;
    logic [CW-1:0] rep_cnt_n;
    logic          rep_phase;
    logic          rep_phase_n;
    logic          stay_held;

    assign stay_held = (state == HELD_UP || state == HELD_DOWN)
                       && (state_n == state);

    always_comb begin
        rep_cnt_n   = '0;
        rep_phase_n = 1'b0;
        rep_fire    = 1'b0;
        if (stay_held) begin
            if (rep_cnt == (rep_phase ? RP_LAST : RD_LAST)) begin
                rep_fire    = 1'b1;
                rep_phase_n = 1'b1;
            end else begin
                rep_cnt_n   = rep_cnt + CW'(1);
                rep_phase_n = rep_phase;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else begin
            rep_cnt   <= rep_cnt_n;
            rep_phase <= rep_phase_n;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign enable_n = start_pulse | rep_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            enable  <= 1'b0;
            up_down <= 1'b0;
        end else begin
            state   <= state_n;
            enable  <= enable_n;
            up_down <= up_down_n;
        end
    end

    assign held = (state != IDLE);

endmodule

// File: tb/tb_updown_button_ctrl.sv
// Self-checking bench for updown_button_ctrl (DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=8); honours AUTO_REPEAT_EN if defined.
module tb_updown_button_ctrl;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;
`ifdef AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_up = 1'b0;
    logic btn_down = 1'b0;
    logic enable;
    logic up_down;
    logic held;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int b2b = 0;
    int dcnt = 0;
    bit prev_en = 1'b0;

    updown_button_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .enable  (enable),
        .up_down (up_down),
        .held    (held)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit up;
        bit dn;
        int len;
        int npulse;
        bit held;
        bit ud;
    } seg_t;

    seg_t segs [24];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge. Also tracks pulses,
    // back-to-back enables and a 2-bit saturating downstream counter.
    task automatic step();
        @(posedge clk);
        #1;
        if (enable) begin
            pulses++;
            if (prev_en) b2b++;
            if (up_down) begin
                if (dcnt < 3) dcnt++;
            end else if (dcnt > 0) begin
                dcnt--;
            end
        end
        prev_en = enable;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn_up = 1'b0;
        btn_down = 1'b0;
        step();
        step();
        rst = 1'b0;
        dcnt = 0;
    endtask

    initial begin
        int err;
        bit exp_en;

        // Four down presses from reset
        for (int i = 0; i < 4; i++) begin
            segs[2*i]   = '{1'b0, 1'b1, 8, 1, 1'b1, 1'b0};
            segs[2*i+1] = '{1'b0, 1'b0, 8, 0, 1'b0, 1'b0};
        end
        // Simultaneous press, release, then a clean up press
        segs[8]  = '{1'b1, 1'b1, 8, 0, 1'b1, 1'b0};
        segs[9]  = '{1'b0, 1'b0, 8, 0, 1'b0, 1'b0};
        segs[10] = '{1'b1, 1'b0, 8, 1, 1'b1, 1'b1};
        segs[11] = '{1'b0, 1'b0, 8, 0, 1'b0, 1'b1};
        // 3-cycle glitch, then a bouncy press
        segs[12] = '{1'b1, 1'b0, 3, 0, 1'b0, 1'b1};
        segs[13] = '{1'b0, 1'b0, 8, 0, 1'b0, 1'b1};
        segs[14] = '{1'b1, 1'b0, 2, 0, 1'b0, 1'b1};
        segs[15] = '{1'b0, 1'b0, 1, 0, 1'b0, 1'b1};
        segs[16] = '{1'b1, 1'b0, 7, 1, 1'b1, 1'b1};
        segs[17] = '{1'b0, 1'b0, 8, 0, 1'b0, 1'b1};
        // Overlapping presses are discarded
        segs[18] = '{1'b1, 1'b0, 8, 1, 1'b1, 1'b1};
        segs[19] = '{1'b1, 1'b1, 8, 0, 1'b1, 1'b1};
        segs[20] = '{1'b1, 1'b0, 8, 0, 1'b1, 1'b1};
        segs[21] = '{1'b0, 1'b0, 8, 0, 1'b0, 1'b1};
        segs[22] = '{1'b0, 1'b1, 8, 1, 1'b1, 1'b0};
        segs[23] = '{1'b0, 1'b0, 8, 0, 1'b0, 1'b0};

        do_reset();
        chk("reset_enable", int'(enable), 0);
        chk("reset_up_down", int'(up_down), 0);
        chk("reset_held", int'(held), 0);

        for (int i = 0; i < 24; i++) begin
            btn_up = segs[i].up;
            btn_down = segs[i].dn;
            pulses = 0;
            repeat (segs[i].len) step();
            chk($sformatf("seg%0d_pulses", i), pulses, segs[i].npulse);
            chk($sformatf("seg%0d_held", i), int'(held), int'(segs[i].held));
            chk($sformatf("seg%0d_up_down", i), int'(up_down), int'(segs[i].ud));
            if (i == 7) chk("saturated_count", dcnt, 0);
        end
        chk("table_final_count", dcnt, 2);

        // Exact latency and long hold (repeat pulses only with the macro)
        btn_up = 1'b1;
        pulses = 0;
        err = 0;
        for (int k = 0; k < 52; k++) begin
            step();
            exp_en = (k == 6) ||
                     (AR && (k == 26 || k == 34 || k == 42 || k == 50));
            if (enable != exp_en) err++;
            if (k == 6) begin
                chk("first_pulse_enable", int'(enable), 1);
                chk("first_pulse_up_down", int'(up_down), 1);
                chk("first_pulse_held", int'(held), 1);
            end
        end
        chk("hold_pattern_errors", err, 0);
        chk("hold_pulse_total", pulses, AR ? 5 : 1);

        btn_up = 1'b0;
        pulses = 0;
        for (int k = 0; k < 7; k++) begin
            step();
            if (k == 5) chk("release_held_k5", int'(held), 1);
            if (k == 6) chk("release_held_k6", int'(held), 0);
        end
        chk("release_pulses", pulses, 0);
        repeat (4) step();

        // Reset 30 cycles after the first pulse while the button is held
        btn_up = 1'b1;
        pulses = 0;
        repeat (37) step();
        chk("pre_reset_pulses", pulses, AR ? 3 : 1);
        rst = 1'b1;
        step();
        chk("mid_reset_outputs", int'({enable, up_down, held}), 0);
        step();
        rst = 1'b0;
        pulses = 0;
        repeat (5) step();
        chk("no_pulse_after_reset", pulses, 0);
        repeat (4) step();
        chk("held_through_reset_pulses", pulses, 1);
        chk("held_through_reset_up_down", int'(up_down), 1);
        chk("held_through_reset_held", int'(held), 1);
        btn_up = 1'b0;
        repeat (10) step();

        chk("back_to_back_enables", b2b, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
